// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with a single outstanding imem request.
// Produces the IF/ID register (instr, pc, pc+4, valid) for the decode stage.
//
// state  | meaning
// S_BOOT | first cycle after reset, no request
// S_REQ  | presenting pc_f, waiting for grant
// S_WAIT | request granted, waiting for response
// S_HOLD | response captured while stalled, waiting for stall release
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f_i,
   input  logic        flush_d_i,
   input  logic        pc_src_e_i,
   input  logic [31:0] pc_target_e_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_id_o,
   output logic [31:0] pc_id_o,
   output logic [31:0] pc_plus_4_id_o,
   output logic        valid_id_o
);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_f, pc_f_nxt;
   logic [31:0] req_pc, req_pc_nxt;
   logic        discard, discard_nxt;
   logic [31:0] hold_instr, hold_pc;
   logic        hold_load;
   logic        new_valid;
   logic [31:0] new_instr, new_pc;
   logic [31:0] instr_id, pc_id, pc_plus_4_id;
   logic        valid_id;
   logic [31:0] redirect_pc;
   logic        unused_target_lsb;

   assign redirect_pc       = {pc_target_e_i[31:2], 2'b00};
   assign unused_target_lsb = ^pc_target_e_i[1:0];

   always_comb begin
      state_nxt   = state;
      pc_f_nxt    = pc_f;
      req_pc_nxt  = req_pc;
      discard_nxt = discard;
      hold_load   = 1'b0;
      new_valid   = 1'b0;
      new_instr   = imem_rdata_i;
      new_pc      = req_pc;
      case (state)
         S_BOOT: state_nxt = S_REQ;
         S_REQ: begin
            if (imem_gnt_i) begin
               req_pc_nxt = pc_f;
               pc_f_nxt   = pc_f + 32'd4;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (discard) begin
                  discard_nxt = 1'b0;
                  state_nxt   = S_REQ;
               end else if (!stall_f_i) begin
                  new_valid = 1'b1;
                  state_nxt = S_REQ;
               end else begin
                  hold_load = 1'b1;
                  state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall_f_i) begin
               new_valid = 1'b1;
               new_instr = hold_instr;
               new_pc    = hold_pc;
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_BOOT;
      endcase

      // A redirect kills whatever is in flight; IF/ID is left to the flush.
      if (pc_src_e_i) begin
         pc_f_nxt  = redirect_pc;
         new_valid = 1'b0;
         hold_load = 1'b0;
         case (state)
            S_REQ: begin
               if (imem_gnt_i) discard_nxt = 1'b1;
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  discard_nxt = 1'b0;
                  state_nxt   = S_REQ;
               end else begin
                  discard_nxt = 1'b1;
               end
            end
            S_HOLD:  state_nxt = S_REQ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_BOOT;
         pc_f       <= RESET_PC;
         req_pc     <= RESET_PC;
         discard    <= 1'b0;
         hold_instr <= NOP_INSTR;
         hold_pc    <= 32'd0;
      end else begin
         state   <= state_nxt;
         pc_f    <= pc_f_nxt;
         req_pc  <= req_pc_nxt;
         discard <= discard_nxt;
         if (hold_load) begin
            hold_instr <= imem_rdata_i;
            hold_pc    <= req_pc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_id     <= NOP_INSTR;
         pc_id        <= 32'd0;
         pc_plus_4_id <= 32'd0;
         valid_id     <= 1'b0;
      end else if (flush_d_i || (!stall_f_i && !new_valid)) begin
         instr_id     <= NOP_INSTR;
         pc_id        <= 32'd0;
         pc_plus_4_id <= 32'd0;
         valid_id     <= 1'b0;
      end else if (!stall_f_i) begin
         instr_id     <= new_instr;
         pc_id        <= new_pc;
         pc_plus_4_id <= new_pc + 32'd4;
         valid_id     <= 1'b1;
      end
   end

   assign imem_req_o     = (state == S_REQ);
   assign imem_addr_o    = pc_f;
   assign instr_id_o     = instr_id;
   assign pc_id_o        = pc_id;
   assign pc_plus_4_id_o = pc_plus_4_id;
   assign valid_id_o     = valid_id;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table for the fetch stage corner cases,
// followed by randomized traffic checked against a transaction-level model.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;
   localparam int          NVEC     = 28;
   localparam int          RST_ROW  = 25;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_f_i, flush_d_i, pc_src_e_i;
   logic [31:0] pc_target_e_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i, imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_id_o, pc_id_o, pc_plus_4_id_o;
   logic        valid_id_o;

   int errors = 0;
   int checks = 0;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .stall_f_i(stall_f_i), .flush_d_i(flush_d_i),
      .pc_src_e_i(pc_src_e_i), .pc_target_e_i(pc_target_e_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i(imem_rdata_i),
      .instr_id_o(instr_id_o), .pc_id_o(pc_id_o),
      .pc_plus_4_id_o(pc_plus_4_id_o), .valid_id_o(valid_id_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        pc_src;
      logic [31:0] tgt;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
      logic        exp_valid;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_A5A5;
   endfunction

   function automatic vec_t mk(input logic st, input logic fl, input logic ps,
                               input logic [31:0] tg, input logic g, input logic rv,
                               input logic [31:0] rd, input logic er,
                               input logic [31:0] ea, input logic [31:0] ei,
                               input logic [31:0] ep, input logic ev);
      vec_t v;
      v.stall = st; v.flush = fl; v.pc_src = ps; v.tgt = tg;
      v.gnt = g; v.rvalid = rv; v.rdata = rd;
      v.exp_req = er; v.exp_addr = ea; v.exp_instr = ei;
      v.exp_pc = ep; v.exp_valid = ev;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                             input logic ev);
      check32({tag, "_instr"}, instr_id_o, ei);
      check32({tag, "_pc"}, pc_id_o, ep);
      check32({tag, "_pc4"}, pc_plus_4_id_o, ev ? ep + 32'd4 : 32'd0);
      check32({tag, "_valid"}, {31'd0, valid_id_o}, {31'd0, ev});
   endtask

   task automatic check_reset(input string tag);
      check32({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
      check32({tag, "_addr"}, imem_addr_o, RESET_PC);
      check_ifid(tag, NOP, 32'd0, 1'b0);
   endtask

   task automatic drive_idle();
      stall_f_i = 1'b0; flush_d_i = 1'b0; pc_src_e_i = 1'b0;
      pc_target_e_i = 32'd0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
      imem_rdata_i = JUNK;
   endtask

   // reference model state for the random phase
   logic        m_outstanding, m_out_stale, m_held, m_newi, m_kill;
   logic [31:0] m_out_addr, m_held_addr, m_naddr, m_exp_pc;
   logic [31:0] m_instr, m_pc;
   logic        m_valid;
   int          m_countdown;
   int          delivered;

   initial begin
      drive_idle();
      vecs[0]  = mk(0,0,0,0,            0,0,JUNK,                 1,32'h0,       NOP,                  32'h0,        0);
      vecs[1]  = mk(0,0,0,0,            1,0,JUNK,                 0,32'h4,       NOP,                  32'h0,        0);
      vecs[2]  = mk(0,0,0,0,            0,1,mem_word(32'h0),      1,32'h4,       mem_word(32'h0),      32'h0,        1);
      vecs[3]  = mk(0,0,0,0,            1,0,JUNK,                 0,32'h8,       NOP,                  32'h0,        0);
      vecs[4]  = mk(0,0,0,0,            0,1,mem_word(32'h4),      1,32'h8,       mem_word(32'h4),      32'h4,        1);
      vecs[5]  = mk(0,0,0,0,            0,0,JUNK,                 1,32'h8,       NOP,                  32'h0,        0);
      vecs[6]  = mk(0,0,0,0,            0,0,JUNK,                 1,32'h8,       NOP,                  32'h0,        0);
      vecs[7]  = mk(0,0,0,0,            0,0,JUNK,                 1,32'h8,       NOP,                  32'h0,        0);
      vecs[8]  = mk(0,0,0,0,            1,0,JUNK,                 0,32'hC,       NOP,                  32'h0,        0);
      vecs[9]  = mk(0,0,0,0,            0,1,mem_word(32'h8),      1,32'hC,       mem_word(32'h8),      32'h8,        1);
      vecs[10] = mk(1,0,0,0,            1,0,JUNK,                 0,32'h10,      mem_word(32'h8),      32'h8,        1);
      vecs[11] = mk(1,0,0,0,            0,1,32'h0010_0093,        0,32'h10,      mem_word(32'h8),      32'h8,        1);
      vecs[12] = mk(1,0,0,0,            0,0,JUNK,                 0,32'h10,      mem_word(32'h8),      32'h8,        1);
      vecs[13] = mk(0,0,0,0,            0,0,JUNK,                 1,32'h10,      32'h0010_0093,        32'hC,        1);
      vecs[14] = mk(0,0,0,0,            1,0,JUNK,                 0,32'h14,      NOP,                  32'h0,        0);
      vecs[15] = mk(0,0,1,32'h102,      0,0,JUNK,                 0,32'h100,     NOP,                  32'h0,        0);
      vecs[16] = mk(0,0,0,0,            0,1,mem_word(32'h10),     1,32'h100,     NOP,                  32'h0,        0);
      vecs[17] = mk(0,0,0,0,            1,0,JUNK,                 0,32'h104,     NOP,                  32'h0,        0);
      vecs[18] = mk(0,0,0,0,            0,1,mem_word(32'h100),    1,32'h104,     mem_word(32'h100),    32'h100,      1);
      vecs[19] = mk(0,0,0,0,            1,0,JUNK,                 0,32'h108,     NOP,                  32'h0,        0);
      vecs[20] = mk(0,1,1,32'h200,      0,1,mem_word(32'h104),    1,32'h200,     NOP,                  32'h0,        0);
      vecs[21] = mk(0,0,1,32'hFFFF_FFFE,0,0,JUNK,                 1,32'hFFFF_FFFC,NOP,                 32'h0,        0);
      vecs[22] = mk(0,0,0,0,            1,0,JUNK,                 0,32'h0,       NOP,                  32'h0,        0);
      vecs[23] = mk(0,0,0,0,            0,1,mem_word(32'hFFFF_FFFC),1,32'h0,     mem_word(32'hFFFF_FFFC),32'hFFFF_FFFC,1);
      vecs[24] = mk(1,0,0,0,            1,0,JUNK,                 0,32'h4,       mem_word(32'hFFFF_FFFC),32'hFFFF_FFFC,1);
      vecs[25] = mk(0,0,0,0,            0,1,JUNK,                 1,32'h0,       NOP,                  32'h0,        0);
      vecs[26] = mk(0,0,0,0,            1,0,JUNK,                 0,32'h4,       NOP,                  32'h0,        0);
      vecs[27] = mk(0,0,0,0,            0,1,mem_word(32'h0),      1,32'h4,       mem_word(32'h0),      32'h0,        1);

      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         if (i == RST_ROW) begin
            // async reset while a response is outstanding (FSM in WAIT)
            drive_idle();
            rst_n = 1'b0;
            #1;
            check_reset("async_reset");
            @(negedge clk);
            rst_n = 1'b1;
         end
         stall_f_i     = vecs[i].stall;
         flush_d_i     = vecs[i].flush;
         pc_src_e_i    = vecs[i].pc_src;
         pc_target_e_i = vecs[i].tgt;
         imem_gnt_i    = vecs[i].gnt;
         imem_rvalid_i = vecs[i].rvalid;
         imem_rdata_i  = vecs[i].rdata;
         @(posedge clk);
         @(negedge clk);
         check32($sformatf("row%0d_req", i), {31'd0, imem_req_o}, {31'd0, vecs[i].exp_req});
         check32($sformatf("row%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
         check_ifid($sformatf("row%0d", i), vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_valid);
      end

      // randomized phase
      drive_idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_outstanding = 1'b0; m_out_stale = 1'b0; m_held = 1'b0;
      m_out_addr = 32'd0; m_held_addr = 32'd0; m_exp_pc = RESET_PC;
      m_instr = NOP; m_pc = 32'd0; m_valid = 1'b0; m_countdown = 0;
      delivered = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         check_ifid("rand_ifid", m_instr, m_pc, m_valid);
         check32("rand_req_while_busy", {31'd0, imem_req_o && (m_outstanding || m_held)}, 32'd0);

         stall_f_i     = ($urandom_range(0, 3) == 0);
         flush_d_i     = 1'b0;
         pc_src_e_i    = ($urandom_range(0, 15) == 0);
         pc_target_e_i = $urandom;
         imem_gnt_i    = imem_req_o && !m_outstanding && !m_held && ($urandom_range(0, 2) != 0);
         imem_rvalid_i = m_outstanding && (m_countdown == 0);
         if (m_outstanding && m_countdown != 0) m_countdown--;
         imem_rdata_i  = imem_rvalid_i ? mem_word(m_out_addr) : $urandom;

         m_kill = pc_src_e_i;
         m_newi = 1'b0;
         m_naddr = 32'd0;
         if (imem_rvalid_i) begin
            m_outstanding = 1'b0;
            if (!m_out_stale && !m_kill) begin
               if (stall_f_i) begin
                  m_held = 1'b1;
                  m_held_addr = m_out_addr;
               end else begin
                  m_newi = 1'b1;
                  m_naddr = m_out_addr;
               end
            end
         end else if (m_held) begin
            if (m_kill) m_held = 1'b0;
            else if (!stall_f_i) begin
               m_newi = 1'b1;
               m_naddr = m_held_addr;
               m_held = 1'b0;
            end
         end
         if (imem_gnt_i) begin
            check32("rand_grant_addr", imem_addr_o, m_exp_pc);
            m_outstanding = 1'b1;
            m_out_addr = m_exp_pc;
            m_out_stale = m_kill;
            m_countdown = $urandom_range(0, 2);
            m_exp_pc = m_exp_pc + 32'd4;
         end else if (m_outstanding && m_kill) begin
            m_out_stale = 1'b1;
         end
         if (m_kill) m_exp_pc = {pc_target_e_i[31:2], 2'b00};
         if (!stall_f_i) begin
            if (m_newi) begin
               m_instr = mem_word(m_naddr);
               m_pc = m_naddr;
               m_valid = 1'b1;
               delivered++;
            end else begin
               m_instr = NOP;
               m_pc = 32'd0;
               m_valid = 1'b0;
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      check_ifid("rand_final", m_instr, m_pc, m_valid);
      check32("rand_progress", {31'd0, delivered >= 100}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
